// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed display scan controller.
package display_pkg;

   // Scan FSM: all anodes off, or one digit lit.
   typedef enum logic {
      DEAD_T = 1'b0,
      SHOW   = 1'b1
   } scan_state_t;

   // Width of one digit code fed to the shared 7-segment decoder.
   localparam int NIB_W = 4;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Load handshake and scan outputs of the display scan controller.
interface display_scan_ctrl_if import display_pkg::*; #(
   parameter int N_DIGITS = 4
) ();

   logic                      load;
   logic [NIB_W*N_DIGITS-1:0] value;
   logic [N_DIGITS-1:0]       dp_in;
   logic                      lz_en;
   logic                      ack;
   logic                      pending;
   logic [N_DIGITS-1:0]       digit_n;
   logic [NIB_W-1:0]          code;
   logic                      blank;
   logic                      dp_n;

   // Producer of display values / consumer of scan outputs.
   modport master (
      output load, value, dp_in, lz_en,
      input  ack, pending, digit_n, code, blank, dp_n
   );

   // The scan controller itself.
   modport slave (
      input  load, value, dp_in, lz_en,
      output ack, pending, digit_n, code, blank, dp_n
   );

endinterface

// File: rtl/display_scan_ctrl_scan_timer.sv
// Interval timer shared by dead-time and on-time phases. The count restarts
// from zero on start; done flags the last cycle of a len-cycle interval, so a
// counter cleared by reset already times the first interval correctly.
module scan_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;

   assign done = (cnt_q == len - CNT_W'(1));

   // Elapsed-cycle count, cleared whenever a new interval begins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (start) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Keeps a tear-free shadow of the displayed value that only changes at frame
// boundaries, and drives anode select, decoder code, decimal point and blank.
module display_scan_ctrl import display_pkg::*; #(
   parameter int N_DIGITS = 4,
   parameter int DIV      = 50000,
   parameter int DEAD     = 8
) (
   input logic                clk,
   input logic                rst_n,
   display_scan_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(((DIV > DEAD) ? DIV : DEAD) + 1);
   localparam int IDX_W = $clog2(N_DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
   localparam logic [CNT_W-1:0] DIV_LEN  = CNT_W'(DIV);
   localparam logic [CNT_W-1:0] DEAD_LEN = CNT_W'(DEAD);

   scan_state_t               state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [CNT_W-1:0]          len;
   logic                      tmr_done;
   logic                      frame_end;
   logic [NIB_W*N_DIGITS-1:0] shadow_q, pend_val_q;
   logic [N_DIGITS-1:0]       shadow_dp_q, pend_dp_q;
   logic                      pending_q, ack_q;
   logic [N_DIGITS-1:0]       lz_mask;
   logic                      lz_run;
   logic [N_DIGITS-1:0]       digit_n_q;
   logic [NIB_W-1:0]          code_q;
   logic                      blank_q, dp_n_q;

   assign len       = (state_q == SHOW) ? DIV_LEN : DEAD_LEN;
   assign frame_end = (state_q == SHOW) && tmr_done && (idx_q == LAST_IDX);

   // The timer restarts on every phase change, which happens exactly on done.
   scan_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .start (tmr_done),
      .len   (len),
      .done  (tmr_done)
   );

   // Scan state and current digit index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DEAD_T;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Alternate dead time and on time; advance the digit when its on time ends.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         DEAD_T: begin
            if (tmr_done) state_d = SHOW;
         end
         SHOW: begin
            if (tmr_done) begin
               state_d = DEAD_T;
               idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
         end
         default: state_d = DEAD_T;
      endcase
   end

   // Digit i is suppressed when it and every more significant nibble are zero;
   // digit 0 always shows so a zero value still reads "0".
   always_comb begin
      lz_mask = '0;
      lz_run  = bus.lz_en;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         lz_run     = lz_run && (shadow_q[i*NIB_W +: NIB_W] == '0);
         lz_mask[i] = lz_run;
      end
   end

   // Pending capture (latest load wins) and commit into the shadow at frame end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q    <= '0;
         shadow_dp_q <= '0;
         pend_val_q  <= '0;
         pend_dp_q   <= '0;
         pending_q   <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         ack_q <= frame_end && pending_q;
         if (frame_end && pending_q) begin
            shadow_q    <= pend_val_q;
            shadow_dp_q <= pend_dp_q;
         end
         if (bus.load) begin
            pend_val_q <= bus.value;
            pend_dp_q  <= bus.dp_in;
            pending_q  <= 1'b1;
         end else if (frame_end) begin
            pending_q  <= 1'b0;
         end
      end
   end

   // Scan outputs registered from the next state so the lit window lines up
   // with the state register; code keeps its last value during dead time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_n_q <= '1;
         code_q    <= '0;
         blank_q   <= 1'b1;
         dp_n_q    <= 1'b1;
      end else if (state_d == SHOW) begin
         digit_n_q <= ~(N_DIGITS'(1) << idx_d);
         code_q    <= shadow_q[idx_d*NIB_W +: NIB_W];
         blank_q   <= lz_mask[idx_d];
         dp_n_q    <= lz_mask[idx_d] | ~shadow_dp_q[idx_d];
      end else begin
         digit_n_q <= '1;
         blank_q   <= 1'b1;
         dp_n_q    <= 1'b1;
      end
   end

   assign bus.ack     = ack_q;
   assign bus.pending = pending_q;
   assign bus.digit_n = digit_n_q;
   assign bus.code    = code_q;
   assign bus.blank   = blank_q;
   assign bus.dp_n    = dp_n_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with N_DIGITS=4, DIV=4, DEAD=2
// (frame = 24 cycles; digit k lit at frame phases 6k+2..6k+5, ack at phase 0).
module tb_display_scan_ctrl;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   samp;
   int   ack_cnt;

   display_scan_ctrl_if #(.N_DIGITS(4)) bus ();

   display_scan_ctrl #(.N_DIGITS(4), .DIV(4), .DEAD(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp;
      logic        lz;
      logic [15:0] exp_code;
      logic [3:0]  exp_blank;
      logic [3:0]  exp_dp_n;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      samp++;
      if (bus.ack === 1'b1) ack_cnt++;
   endtask

   task automatic wait_phase(input int ph);
      for (int i = 0; i < 30; i++) begin
         if ((samp % 24) == ph) break;
         step();
      end
   endtask

   task automatic wait_ack(input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus.ack === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      chk({tag, "_ack_seen"}, 32'(got), 32'd1);
      chk({tag, "_ack_phase"}, 32'(samp % 24), 32'd0);
   endtask

   task automatic check_frame(input logic [15:0] ec, input logic [3:0] eb,
                              input logic [3:0] ed, input string tag);
      for (int d = 0; d < 4; d++) begin
         logic [3:0] want;
         logic [3:0] one;
         bit         found;
         one   = 4'b0001;
         want  = ~(one << d);
         found = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if (bus.digit_n === want) begin
               found = 1'b1;
               break;
            end
            step();
         end
         chk($sformatf("%s_d%0d_lit", tag, d), 32'(found), 32'd1);
         if (found) begin
            chk($sformatf("%s_d%0d_code", tag, d), 32'(bus.code), 32'(ec[d*4 +: 4]));
            chk($sformatf("%s_d%0d_blank", tag, d), 32'(bus.blank), 32'(eb[d]));
            chk($sformatf("%s_d%0d_dp_n", tag, d), 32'(bus.dp_n), 32'(ed[d]));
         end
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
      bus.load  = 1'b1;
      bus.value = v;
      bus.dp_in = dp;
      step();
      bus.load  = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_digit_n"}, 32'(bus.digit_n), 32'hF);
      chk({tag, "_code"},    32'(bus.code),    32'h0);
      chk({tag, "_blank"},   32'(bus.blank),   32'h1);
      chk({tag, "_dp_n"},    32'(bus.dp_n),    32'h1);
      chk({tag, "_ack"},     32'(bus.ack),     32'h0);
      chk({tag, "_pending"}, 32'(bus.pending), 32'h0);
   endtask

   initial begin
      int base;
      int period;
      total     = 0;
      bad       = 0;
      samp      = 0;
      ack_cnt   = 0;
      rst_n     = 1'b0;
      bus.load  = 1'b0;
      bus.value = '0;
      bus.dp_in = '0;
      bus.lz_en = 1'b0;

      //            value     dp       lz    code      blank    dp_n
      vecs[0] = '{16'h12A7, 4'b0100, 1'b0, 16'h12A7, 4'b0000, 4'b1011};
      vecs[1] = '{16'h0050, 4'b0000, 1'b1, 16'h0050, 4'b1100, 4'b1111};
      vecs[2] = '{16'h0000, 4'b0000, 1'b1, 16'h0000, 4'b1110, 4'b1111};
      vecs[3] = '{16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'b1111};
      vecs[4] = '{16'h0050, 4'b1111, 1'b1, 16'h0050, 4'b1100, 4'b1100};
      vecs[5] = '{16'hF00E, 4'b0001, 1'b1, 16'hF00E, 4'b0000, 4'b1110};
      vecs[6] = '{16'h0101, 4'b1000, 1'b1, 16'h0101, 4'b1000, 4'b1111};

      // Reset state and release timing.
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("in_reset");
      rst_n = 1'b1;
      samp  = 0;
      chk("rel_s0_digit", 32'(bus.digit_n), 32'hF);
      chk("rel_s0_blank", 32'(bus.blank), 32'h1);
      step();
      chk("rel_s1_digit", 32'(bus.digit_n), 32'hF);
      chk("rel_s1_blank", 32'(bus.blank), 32'h1);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("rel_s%0d_digit", samp), 32'(bus.digit_n), 32'hE);
      end
      step();
      chk("rel_s6_digit", 32'(bus.digit_n), 32'hF);
      period = -1;
      for (int i = 0; i < 40; i++) begin
         if (bus.digit_n === 4'hE) begin
            period = samp - 2;
            break;
         end
         step();
      end
      chk("frame_period", 32'(period), 32'd24);

      // Table of single loads followed by one full displayed frame.
      foreach (vecs[n]) begin
         wait_phase(4);
         bus.lz_en = vecs[n].lz;
         do_load(vecs[n].value, vecs[n].dp);
         chk($sformatf("v%0d_pending", n), 32'(bus.pending), 32'd1);
         wait_ack($sformatf("v%0d", n));
         chk($sformatf("v%0d_pend_clr", n), 32'(bus.pending), 32'd0);
         step();
         chk($sformatf("v%0d_ack_pulse", n), 32'(bus.ack), 32'd0);
         check_frame(vecs[n].exp_code, vecs[n].exp_blank, vecs[n].exp_dp_n,
                     $sformatf("v%0d", n));
      end

      // Two loads before one boundary: latest wins, single ack.
      bus.lz_en = 1'b0;
      wait_phase(4);
      base = ack_cnt;
      do_load(16'h1111, 4'b0000);
      do_load(16'h2222, 4'b0000);
      wait_ack("two");
      check_frame(16'h2222, 4'b0000, 4'b1111, "two");
      chk("two_ack_count", 32'(ack_cnt - base), 32'd1);

      // Load on the frame-boundary cycle: old commits, new stays pending.
      wait_phase(4);
      do_load(16'h3333, 4'b0000);
      chk("bnd_pending1", 32'(bus.pending), 32'd1);
      wait_phase(23);
      do_load(16'h4444, 4'b0000);
      chk("bnd_ack1", 32'(bus.ack), 32'd1);
      chk("bnd_ack1_phase", 32'(samp % 24), 32'd0);
      chk("bnd_pending_kept", 32'(bus.pending), 32'd1);
      check_frame(16'h3333, 4'b0000, 4'b1111, "bnd_old");
      wait_ack("bnd2");
      chk("bnd_pending_clr", 32'(bus.pending), 32'd0);
      check_frame(16'h4444, 4'b0000, 4'b1111, "bnd_new");

      // Reset mid-frame with a load pending.
      wait_phase(4);
      do_load(16'h9999, 4'b1111);
      chk("rst_pending_set", 32'(bus.pending), 32'd1);
      repeat (3) step();
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst_async");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      samp  = 0;
      base  = ack_cnt;
      check_frame(16'h0000, 4'b0000, 4'b1111, "rst_shadow");
      while (samp < 50) step();
      chk("rst_no_ack", 32'(ack_cnt - base), 32'd0);
      chk("rst_pending_clr", 32'(bus.pending), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
